vec_wb_unit: RTL and testbench

//  Writeback initiator for the 14x48-bit vector register file (single write port we3/ra3/wd3).

---
 rtl/vec_wb_unit_pkg.sv | 29 ++
 rtl/vec_wb_unit_merge.sv | 24 ++
 rtl/vec_wb_unit.sv | 167 ++++++++++++++++
 tb/tb_vec_wb_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_wb_unit_pkg.sv
// vec_pkg: shared types and sizes for the vector register-file writeback unit.
//   VLEN/LANES/NREGS describe the 14 x 48-bit register file (6 x 8-bit lanes).
//   STARVE bounds consecutive MEM grants while an ALU request is waiting.
//   wb_req_t is one latched writeback request; wb_state_e is the writeback FSM.
package vec_pkg;

  localparam int unsigned VLEN   = 48;
  localparam int unsigned LANES  = 6;
  localparam int unsigned NREGS  = 14;
  localparam int unsigned STARVE = 4;

  typedef struct packed {
    logic [3:0]       rd;
    logic [VLEN-1:0]  data;
    logic [LANES-1:0] mask;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } wb_state_e;

  // True when rd addresses an implemented register.
  function automatic logic reg_legal(input logic [3:0] rd);
    return 32'(rd) < NREGS;
  endfunction

endpackage

// File: rtl/vec_wb_unit_merge.sv
// wb_lane_merge: combinational per-lane byte merge for read-modify-write.
//   old_i    : current register contents (VLEN)
//   new_i    : incoming write data (VLEN)
//   mask_i   : lane enables, bit i selects new_i bits 8i+7:8i (LANES)
//   merged_o : old_i with the enabled lanes replaced by new_i (VLEN)
module wb_lane_merge
  import vec_pkg::*;
(
  input  logic [VLEN-1:0]  old_i,
  input  logic [VLEN-1:0]  new_i,
  input  logic [LANES-1:0] mask_i,
  output logic [VLEN-1:0]  merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (mask_i[i]) begin
        merged_o[8*i +: 8] = new_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/vec_wb_unit.sv
// vec_wb_unit: writeback initiator for the 14 x 48-bit vector register file.
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   rf_init               : register file initialising; blocks new accepts
//   alu_* / mem_*         : valid/ready writeback request ports (rd, data, lane mask)
//   rf_we/rf_wa/rf_wd     : registered write port (we3/ra3/wd3)
//   rf_ra / rf_rd         : spare combinational read port used for partial-mask RMW
//   pend_mask             : bit r set while a write to register r is held here
//   err_badreg            : one-cycle pulse after accepting a request with rd >= NREGS
// MEM has priority; after STARVE consecutive MEM grants with ALU waiting, ALU wins once.
module vec_wb_unit
  import vec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rf_init,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [3:0]       alu_rd,
  input  logic [VLEN-1:0]  alu_data,
  input  logic [LANES-1:0] alu_mask,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [3:0]       mem_rd,
  input  logic [VLEN-1:0]  mem_data,
  input  logic [LANES-1:0] mem_mask,
  output logic             rf_we,
  output logic [3:0]       rf_wa,
  output logic [VLEN-1:0]  rf_wd,
  output logic [3:0]       rf_ra,
  input  logic [VLEN-1:0]  rf_rd,
  output logic [NREGS-1:0] pend_mask,
  output logic             err_badreg
);

  localparam int unsigned SW = $clog2(STARVE + 1);

  wb_state_e        state_q, state_d;
  wb_req_t          req_q, req_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic             we_q, we_d;
  logic [3:0]       wa_q, wa_d;
  logic [VLEN-1:0]  wd_q, wd_d;
  logic             err_q, err_d;

  logic             open_win;
  logic             alu_turn;
  logic             mem_gnt;
  logic             alu_gnt;
  logic             accept;
  logic             new_legal;
  logic             new_writes;
  wb_req_t          new_req;
  logic [VLEN-1:0]  merged;

  wb_lane_merge u_merge (
    .old_i    (rf_rd),
    .new_i    (req_q.data),
    .mask_i   (req_q.mask),
    .merged_o (merged)
  );

  // Arbitration: readies are the grants themselves, so at most one is high.
  // rst_n gates the window so both readies read 0 while reset is held.
  always_comb begin
    open_win = rst_n && !rf_init && ((state_q == IDLE) || (state_q == WRITE));
    alu_turn = 32'(starve_q) >= STARVE;
    mem_gnt  = open_win && mem_valid && !(alu_valid && alu_turn);
    alu_gnt  = open_win && alu_valid && !mem_gnt;
    accept   = mem_gnt || alu_gnt;

    if (mem_gnt) begin
      new_req.rd   = mem_rd;
      new_req.data = mem_data;
      new_req.mask = mem_mask;
    end else begin
      new_req.rd   = alu_rd;
      new_req.data = alu_data;
      new_req.mask = alu_mask;
    end

    new_legal  = reg_legal(new_req.rd);
    new_writes = new_legal && (|new_req.mask);
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    starve_d = starve_q;
    pend_d   = pend_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    err_d    = 1'b0;

    case (state_q)
      READ: begin
        state_d = WRITE;
        we_d    = 1'b1;
        wa_d    = req_q.rd;
        wd_d    = merged;
      end
      WRITE: begin
        pend_d[wa_q] = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Applied after the WRITE clear so a same-cycle set of the same bit wins.
    if (accept) begin
      req_d = new_req;
      err_d = !new_legal;
      if (new_writes) begin
        pend_d[new_req.rd] = 1'b1;
        if (&new_req.mask) begin
          state_d = WRITE;
          we_d    = 1'b1;
          wa_d    = new_req.rd;
          wd_d    = new_req.data;
        end else begin
          state_d = READ;
        end
      end else begin
        state_d = IDLE;
      end
    end

    if (mem_gnt && alu_valid) begin
      starve_d = starve_q + SW'(1);
    end else if (alu_gnt) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      starve_q <= '0;
      pend_q   <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
    end
  end

  assign alu_ready  = alu_gnt;
  assign mem_ready  = mem_gnt;
  assign rf_we      = we_q;
  assign rf_wa      = wa_q;
  assign rf_wd      = wd_q;
  assign rf_ra      = req_q.rd;
  assign pend_mask  = pend_q;
  assign err_badreg = err_q;

endmodule

// File: tb/tb_vec_wb_unit.sv
// tb_vec_wb_unit: directed self-checking bench for vec_wb_unit with a small
// register-file model behind the write and RMW read ports.
module tb_vec_wb_unit;

  logic        clk;
  logic        rst_n;
  logic        rf_init;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_rd;
  logic [47:0] alu_data;
  logic [5:0]  alu_mask;
  logic        mem_valid, mem_ready;
  logic [3:0]  mem_rd;
  logic [47:0] mem_data;
  logic [5:0]  mem_mask;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [47:0] rf_wd;
  logic [3:0]  rf_ra;
  logic [47:0] rf_rd;
  logic [13:0] pend_mask;
  logic        err_badreg;

  logic [47:0] rf [16];
  logic        pre_en;
  logic [3:0]  pre_a;
  logic [47:0] pre_d;

  int n_chk  = 0;
  int n_pass = 0;
  logic exp_alu;

  vec_wb_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rf_init    (rf_init),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_mask   (alu_mask),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_mask   (mem_mask),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .rf_ra      (rf_ra),
    .rf_rd      (rf_rd),
    .pend_mask  (pend_mask),
    .err_badreg (err_badreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: one write port plus a bench preload port.
  always @(posedge clk) begin
    if (pre_en) rf[pre_a] <= pre_d;
    if (rf_we)  rf[rf_wa] <= rf_wd;
  end
  assign rf_rd = rf[rf_ra];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic preload(input logic [3:0] a, input logic [47:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rf_init = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0; alu_mask = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0; mem_mask = '0;
    pre_en = 1'b0; pre_a = '0; pre_d = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_we",   rf_we, 0);
    chk("rst_wa",   rf_wa, 0);
    chk("rst_wd",   rf_wd, 0);
    chk("rst_ra",   rf_ra, 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_err",  err_badreg, 0);
    chk("rst_rdy",  {alu_ready, mem_ready}, 0);
    rst_n = 1'b1;

    preload(4'd10, 48'hFFFFFFFFFFFF);
    preload(4'd6,  48'h111111111111);
    preload(4'd8,  48'h222222222222);

    // 1: full-mask MEM write
    @(negedge clk);
    mem_valid = 1'b1; mem_rd = 4'd4; mem_data = 48'h0123456789AB; mem_mask = 6'h3F;
    #1;
    chk("t1_mem_rdy", mem_ready, 1);
    chk("t1_alu_rdy", alu_ready, 0);
    @(negedge clk);
    mem_valid = 1'b0;
    chk("t1_we",   rf_we, 1);
    chk("t1_wa",   rf_wa, 4);
    chk("t1_wd",   rf_wd, 48'h0123456789AB);
    chk("t1_pend", pend_mask, 14'h0010);
    @(negedge clk);
    chk("t1_we_off",   rf_we, 0);
    chk("t1_pend_off", pend_mask, 0);

    // 2: partial-mask ALU write -> RMW
    alu_valid = 1'b1; alu_rd = 4'd10; alu_data = '0; alu_mask = 6'b000011;
    #1;
    chk("t2_alu_rdy", alu_ready, 1);
    @(negedge clk);
    alu_valid = 1'b0;
    chk("t2_ra",      rf_ra, 10);
    chk("t2_we_read", rf_we, 0);
    chk("t2_pend",    pend_mask, 14'h0400);
    #1;
    chk("t2_rdy_read", {alu_ready, mem_ready}, 0);
    @(negedge clk);
    chk("t2_we", rf_we, 1);
    chk("t2_wa", rf_wa, 10);
    chk("t2_wd", rf_wd, 48'hFFFFFFFF0000);
    @(negedge clk);
    chk("t2_we_off",   rf_we, 0);
    chk("t2_pend_off", pend_mask, 0);

    // 3: both sources held, full masks -> MEM x4, ALU x1 ...
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 48'hA1A1A1A1A1A1; alu_mask = 6'h3F;
    mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 48'hB2B2B2B2B2B2; mem_mask = 6'h3F;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_alu = (i % 5 == 4);
      chk("t3_alu_rdy", alu_ready, exp_alu);
      chk("t3_mem_rdy", mem_ready, !exp_alu);
      @(negedge clk);
      chk("t3_we", rf_we, 1);
      chk("t3_wa", rf_wa, exp_alu ? 4'd1 : 4'd2);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk("t3_we_off", rf_we, 0);

    // 4: back-to-back partial writes to rd=6
    mem_valid = 1'b1; mem_rd = 4'd6; mem_data = 48'hAAAAAAAAAAAA; mem_mask = 6'h01;
    #1;
    chk("t4_rdy1", mem_ready, 1);
    @(negedge clk);
    mem_data = 48'hBBBBBBBBBBBB; mem_mask = 6'h02;
    #1;
    chk("t4_rdy_read", mem_ready, 0);
    @(negedge clk);
    chk("t4_we1", rf_we, 1);
    chk("t4_wd1", rf_wd, 48'h1111111111AA);
    #1;
    chk("t4_rdy2", mem_ready, 1);
    @(negedge clk);
    mem_valid = 1'b0;
    chk("t4_pend_kept", pend_mask, 14'h0040);
    chk("t4_rd_seen",   rf_rd, 48'h1111111111AA);
    @(negedge clk);
    chk("t4_we2", rf_we, 1);
    chk("t4_wd2", rf_wd, 48'h11111111BBAA);
    @(negedge clk);
    chk("t4_rf6",   rf[6], 48'h11111111BBAA);
    chk("t4_pend0", pend_mask, 0);

    // 5a: illegal rd
    mem_valid = 1'b1; mem_rd = 4'd15; mem_data = 48'h555555555555; mem_mask = 6'h3F;
    #1;
    chk("t5_rdy", mem_ready, 1);
    @(negedge clk);
    mem_valid = 1'b0;
    chk("t5_err",  err_badreg, 1);
    chk("t5_we",   rf_we, 0);
    chk("t5_pend", pend_mask, 0);
    @(negedge clk);
    chk("t5_err_off", err_badreg, 0);

    // 5b: zero mask is accepted but writes nothing
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 48'h777777777777; alu_mask = 6'h00;
    #1;
    chk("t5_zm_rdy", alu_ready, 1);
    @(negedge clk);
    alu_valid = 1'b0;
    chk("t5_zm_we",   rf_we, 0);
    chk("t5_zm_pend", pend_mask, 0);
    chk("t5_zm_err",  err_badreg, 0);

    // 5c: rf_init blocks accepts
    @(negedge clk);
    rf_init = 1'b1;
    alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 48'hC5C5C5C5C5C5; alu_mask = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_init_rdy", alu_ready, 0);
      @(negedge clk);
      chk("t5_init_we", rf_we, 0);
    end
    rf_init = 1'b0;
    #1;
    chk("t5_init_rel", alu_ready, 1);
    @(negedge clk);
    alu_valid = 1'b0;
    chk("t5_rel_we", rf_we, 1);
    chk("t5_rel_wa", rf_wa, 5);

    // 6: reset during the READ of a partial write
    @(negedge clk);
    mem_valid = 1'b1; mem_rd = 4'd8; mem_data = 48'h999999999999; mem_mask = 6'h0F;
    @(negedge clk);
    mem_valid = 1'b0;
    chk("t6_ra", rf_ra, 8);
    #2;
    rst_n = 1'b0;
    mem_valid = 1'b1; mem_mask = 6'h3F;
    #1;
    chk("t6_we",   rf_we, 0);
    chk("t6_ra0",  rf_ra, 0);
    chk("t6_pend", pend_mask, 0);
    chk("t6_rdy",  mem_ready, 0);
    @(negedge clk);
    mem_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t6_no_we", rf_we, 0);
    end
    chk("t6_rf8", rf[8], 48'h222222222222);
    mem_valid = 1'b1; mem_rd = 4'd8; mem_data = 48'h313131313131; mem_mask = 6'h3F;
    #1;
    chk("t6_next_rdy", mem_ready, 1);
    @(negedge clk);
    mem_valid = 1'b0;
    chk("t6_next_we", rf_we, 1);
    chk("t6_next_wd", rf_wd, 48'h313131313131);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
